// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one fixed-latency single-port memory between fetch and load/store.
// Define IMEM_ARB_STARVE_GUARD_EN to build the fetch starvation guard.
module imem_dmem_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [AWIDTH-1:0]     if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DWIDTH-1:0]     if_rdata_o,
  output logic                  if_stall_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [AWIDTH-1:0]     d_addr_i,
  input  logic [DWIDTH-1:0]     d_wdata_i,
  input  logic [DWIDTH/8-1:0]   d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DWIDTH-1:0]     d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AWIDTH-1:0]     mem_addr_o,
  output logic [DWIDTH-1:0]     mem_wdata_o,
  output logic [DWIDTH/8-1:0]   mem_be_o,
  input  logic [DWIDTH-1:0]     mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  state_t state, state_d;
  logic [2:0] lat_cnt, lat_d;
  logic drop_q, drop_d, we_q, we_d;
  logic resp, can_gnt, force_if, gnt_d, gnt_if;
  if (MEM_LATENCY < 1 || MEM_LATENCY > 7 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
    $error("imem_dmem_arbiter: MEM_LATENCY or STARVE_LIMIT out of range");
  end
`ifdef IMEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt, starve_d;
  assign force_if = starve_cnt == 4'(STARVE_LIMIT);
  assign starve_d = gnt_if ? 4'd0 : (gnt_d && if_req_i && !force_if) ? starve_cnt + 4'd1 : starve_cnt;
  always_ff @(posedge clk) starve_cnt <= rst ? 4'd0 : starve_d;
`else
  assign force_if = 1'b0;
`endif
  // Nothing is granted or returned while rst is high, so a reset abandons any access cleanly.
  assign resp    = !rst && state != IDLE && lat_cnt == 3'd0;
  assign can_gnt = !rst && (state == IDLE || resp);
  assign gnt_d   = can_gnt && d_req_i && !(if_req_i && force_if);
  assign gnt_if  = can_gnt && if_req_i && !gnt_d;
  assign if_gnt_o    = gnt_if;
  assign d_gnt_o     = gnt_d;
  assign if_stall_o  = if_req_i && !gnt_if;
  assign if_rvalid_o = resp && state == BUSY_IF && !drop_q && !if_flush_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rvalid_o  = resp && state == BUSY_D;
  assign d_rdata_o   = (d_rvalid_o && !we_q) ? mem_rdata_i : '0;
  assign mem_req_o   = gnt_d || gnt_if;
  assign mem_we_o    = gnt_d && d_we_i;
  assign mem_addr_o  = gnt_d ? d_addr_i : gnt_if ? if_addr_i : '0;
  assign mem_wdata_o = gnt_d ? d_wdata_i : '0;
  assign mem_be_o    = gnt_d ? d_be_i : gnt_if ? '1 : '0;
  always_comb begin
    state_d = state;
    lat_d   = lat_cnt;
    drop_d  = drop_q;
    we_d    = we_q;
    if (gnt_d || gnt_if) begin
      state_d = gnt_d ? BUSY_D : BUSY_IF;
      lat_d   = 3'(MEM_LATENCY - 1);
      drop_d  = 1'b0;
      we_d    = gnt_d && d_we_i;
    end else if (resp) begin
      state_d = IDLE;
      drop_d  = 1'b0;
    end else if (state != IDLE) begin
      lat_d  = lat_cnt - 3'd1;
      drop_d = drop_q || (state == BUSY_IF && if_flush_i);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 3'd0;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_d;
      lat_cnt <= lat_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
    end
  end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: scoreboard bench for imem_dmem_arbiter with a latency-3 memory model.
module tb_imem_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 3;
  localparam int SL = 4;
  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t if_q[$];
  exp_t d_q[$];
  exp_t me;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic clk, rst;
  logic if_req_i, if_flush_i, if_gnt_o, if_rvalid_o, if_stall_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic [DW/8-1:0] d_be_i;
  logic mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [DW/8-1:0] mem_be_o;
  logic [AW:0] pipe [ML];

  imem_dmem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MEM_LATENCY(ML), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Memory model: data for an address appears ML cycles after its request strobe.
  always @(posedge clk) begin
    pipe[0] <= {mem_req_o, mem_addr_o};
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    cyc <= cyc + 1;
  end
  assign mem_rdata_i = pipe[ML-1][AW] ? rd(pipe[ML-1][AW-1:0]) : '0;

  always @(negedge clk) begin
    if (if_rvalid_o) begin
      checks++;
      if (if_q.size() == 0) begin
        errors++;
        $display("FAIL if_rvalid_unexpected cyc=%0d got=%h exp=none", cyc, if_rdata_o);
      end else begin
        me = if_q.pop_front();
        if (if_rdata_o !== me.data || cyc != me.cyc) begin
          errors++;
          $display("FAIL if_resp got=%h@%0d exp=%h@%0d", if_rdata_o, cyc, me.data, me.cyc);
        end
      end
    end else if (if_rdata_o !== '0) begin
      checks++;
      errors++;
      $display("FAIL if_rdata_idle got=%h exp=0", if_rdata_o);
    end
    if (d_rvalid_o) begin
      checks++;
      if (d_q.size() == 0) begin
        errors++;
        $display("FAIL d_rvalid_unexpected cyc=%0d got=%h exp=none", cyc, d_rdata_o);
      end else begin
        me = d_q.pop_front();
        if (d_rdata_o !== me.data || cyc != me.cyc) begin
          errors++;
          $display("FAIL d_resp got=%h@%0d exp=%h@%0d", d_rdata_o, cyc, me.data, me.cyc);
        end
      end
    end else if (d_rdata_o !== '0) begin
      checks++;
      errors++;
      $display("FAIL d_rdata_idle got=%h exp=0", d_rdata_o);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (ML + 1) tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o, d_gnt_o, d_rvalid_o, d_rdata_o,
         mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got mem_req=%b mem_addr=%h if_gnt=%b d_gnt=%b exp=all 0",
               mem_req_o, mem_addr_o, if_gnt_o, d_gnt_o);
    end
    tick;
  endtask

  task automatic test_fetch_b2b;
    for (int n = 0; n < 2; n++) begin
      if_req_i = 1'b1;
      if_addr_i = 32'h1000 + 32'(4 * n);
      for (int k = 0; k < ML; k++) begin
        @(negedge clk);
        checks++;
        if (if_gnt_o !== 1'(k == 0) || if_stall_o !== 1'(k != 0)) begin
          errors++;
          $display("FAIL fetch_gnt n=%0d k=%0d got gnt=%b stall=%b exp gnt=%b stall=%b",
                   n, k, if_gnt_o, if_stall_o, k == 0, k != 0);
        end
        if (k == 0) begin
          checks++;
          if (mem_req_o !== 1'b1 || mem_addr_o !== if_addr_i || mem_be_o !== 4'hF || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_mem got req=%b addr=%h be=%h we=%b exp req=1 addr=%h be=f we=0",
                     mem_req_o, mem_addr_o, mem_be_o, mem_we_o, if_addr_i);
          end
          if_q.push_back('{data: rd(if_addr_i), cyc: cyc + ML});
        end
        tick;
      end
    end
    if_req_i = 1'b0;
    repeat (ML) tick;
  endtask

  task automatic test_contend;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2000;
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    @(negedge clk);
    checks++;
    if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0 || if_stall_o !== 1'b1 || mem_addr_o !== 32'h2000) begin
      errors++;
      $display("FAIL contend_first got d_gnt=%b if_gnt=%b stall=%b addr=%h exp 1 0 1 00002000",
               d_gnt_o, if_gnt_o, if_stall_o, mem_addr_o);
    end
    d_q.push_back('{data: rd(32'h2000), cyc: cyc + ML});
    tick;
    d_req_i = 1'b0;
    for (int k = 1; k < ML; k++) begin
      @(negedge clk);
      checks++;
      if (if_gnt_o !== 1'b0 || if_stall_o !== 1'b1) begin
        errors++;
        $display("FAIL contend_wait k=%0d got gnt=%b stall=%b exp gnt=0 stall=1", k, if_gnt_o, if_stall_o);
      end
      tick;
    end
    @(negedge clk);
    checks++;
    if (if_gnt_o !== 1'b1 || if_stall_o !== 1'b0 || d_rvalid_o !== 1'b1 || mem_addr_o !== 32'h1000) begin
      errors++;
      $display("FAIL contend_fetch got if_gnt=%b stall=%b d_rvalid=%b addr=%h exp 1 0 1 00001000",
               if_gnt_o, if_stall_o, d_rvalid_o, mem_addr_o);
    end
    if_q.push_back('{data: rd(32'h1000), cyc: cyc + ML});
    tick;
    if_req_i = 1'b0;
    repeat (ML) tick;
  endtask

  task automatic test_store;
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
    d_addr_i = 32'h3000; d_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (d_gnt_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 ||
        mem_addr_o !== 32'h3000 || mem_wdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_mem got gnt=%b we=%b be=%b addr=%h wdata=%h exp 1 1 0011 00003000 deadbeef",
               d_gnt_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    d_q.push_back('{data: '0, cyc: cyc + ML});
    tick;
    d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_wdata_i = '0;
    repeat (ML) tick;
  endtask

  task automatic test_starve;
    logic exp_if;
    if_req_i = 1'b1; if_addr_i = 32'h4000;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h2100;
    for (int n = 0; n < 6; n++) begin
`ifdef IMEM_ARB_STARVE_GUARD_EN
      exp_if = (n == SL);
`else
      exp_if = 1'b0;
`endif
      @(negedge clk);
      checks++;
      if (if_gnt_o !== exp_if || d_gnt_o !== !exp_if) begin
        errors++;
        $display("FAIL starve_opp%0d got if_gnt=%b d_gnt=%b exp if_gnt=%b d_gnt=%b",
                 n + 1, if_gnt_o, d_gnt_o, exp_if, !exp_if);
      end
      if (exp_if) if_q.push_back('{data: rd(32'h4000), cyc: cyc + ML});
      else d_q.push_back('{data: rd(d_addr_i), cyc: cyc + ML});
      tick;
      if (exp_if) if_req_i = 1'b0;
      else d_addr_i = d_addr_i + 32'h10;
      repeat (ML - 1) tick;
    end
    d_req_i = 1'b0; if_req_i = 1'b0; d_be_i = '0;
    repeat (ML) tick;
  endtask

  task automatic test_flush;
    if_req_i = 1'b1; if_addr_i = 32'h5000;
    @(negedge clk);
    checks++;
    if (if_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_first_gnt got=%b exp=1", if_gnt_o);
    end
    tick;
    if_addr_i = 32'h5004; if_flush_i = 1'b1;
    for (int k = 1; k < ML; k++) begin
      @(negedge clk);
      checks++;
      if (if_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_wait k=%0d got gnt=%b exp=0", k, if_gnt_o);
      end
      tick;
      if_flush_i = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (if_gnt_o !== 1'b1 || if_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_regrant got gnt=%b rvalid=%b exp gnt=1 rvalid=0", if_gnt_o, if_rvalid_o);
    end
    tick;
    if_addr_i = 32'h5008;
    repeat (ML - 1) tick;
    if_flush_i = 1'b1;
    @(negedge clk);
    checks++;
    if (if_gnt_o !== 1'b1 || if_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_resp_cycle got gnt=%b rvalid=%b exp gnt=1 rvalid=0", if_gnt_o, if_rvalid_o);
    end
    if_q.push_back('{data: rd(32'h5008), cyc: cyc + ML});
    tick;
    if_flush_i = 1'b0; if_req_i = 1'b0;
    repeat (ML) tick;
  endtask

  task automatic test_reset_mid;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h6000;
    @(negedge clk);
    checks++;
    if (d_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt got=%b exp=1", d_gnt_o);
    end
    tick;
    d_req_i = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o, d_gnt_o, d_rvalid_o, d_rdata_o,
         mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got d_rvalid=%b mem_req=%b mem_addr=%h exp=all 0",
               d_rvalid_o, mem_req_o, mem_addr_o);
    end
    repeat (ML + 1) tick;
    d_req_i = 1'b1;
    @(negedge clk);
    tick;
    d_req_i = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h7000;
    @(negedge clk);
    checks++;
    if (if_gnt_o !== 1'b1 || mem_addr_o !== 32'h7000 || d_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_fetch got gnt=%b addr=%h d_rvalid=%b exp gnt=1 addr=00007000 d_rvalid=0",
               if_gnt_o, mem_addr_o, d_rvalid_o);
    end
    if_q.push_back('{data: rd(32'h7000), cyc: cyc + ML});
    tick;
    if_req_i = 1'b0;
    repeat (ML + 1) tick;
  endtask

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    test_reset;
    test_fetch_b2b;
    test_contend;
    test_store;
    test_starve;
    test_flush;
    test_reset_mid;
    checks++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got if=%0d d=%0d exp 0 0", if_q.size(), d_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Arbiter and sequencer that shares one single-port, fixed-latency unified memory between the fetch stage (instruction requests) and the load/store unit (data requests). It grants at most one access at a time and tracks the outstanding access until its response returns. It routes the response back to the owner and drives the fetch stall. It sits between the pipeline and the memory model, replacing separate instruction and data ports.

## Interface
Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- MEM_LATENCY, 1, cycles from mem_req_o to valid mem_rdata_i; legal range 1..7
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win; legal range 1..15

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request, held until granted
- if_addr_i  in  AWIDTH  fetch address
- if_flush_i  in  1  discard any outstanding fetch response
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DWIDTH  fetched instruction
- if_stall_o  out  1  fetch must hold its PC this cycle
- d_req_i  in  1  data request, held until granted
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  AWIDTH  data address
- d_wdata_i  in  DWIDTH  store data
- d_be_i  in  DWIDTH/8  byte enables
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  load data or store acknowledge valid
- d_rdata_o  out  DWIDTH  load data; 0 for stores
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write
- mem_addr_o  out  AWIDTH  memory address
- mem_wdata_o  out  DWIDTH  memory write data
- mem_be_o  out  DWIDTH/8  memory byte enables; all ones for fetch
- mem_rdata_i  in  DWIDTH  memory read data, valid MEM_LATENCY cycles after mem_req_o

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - BUSY_IF: fetch access outstanding.
  - BUSY_D: data access outstanding.
- Grant rule: a grant is issued combinationally in the same cycle as the request.
  - Grants may issue in IDLE.
  - Grants may also issue in the final BUSY cycle, i.e. the cycle the response is returned.
- Arbitration: data has priority over fetch.
  - A fetch loss is a cycle where if_req_i=1, a grant is issued and the grant goes to data.
  - Each fetch loss increments starve_cnt.
  - When starve_cnt == STARVE_LIMIT, fetch wins the next contested grant.
  - starve_cnt clears on every fetch grant.
- Grant cycle: mem_req_o=1, and mem_* are driven from the winner's inputs.
  - lat_cnt loads MEM_LATENCY-1.
  - The owner is recorded.
- BUSY: lat_cnt decrements each cycle. At lat_cnt==0 the response cycle occurs:
  - The owner's rvalid is asserted with rdata = mem_rdata_i; for stores, d_rdata_o = 0.
  - The FSM moves to the new grant's state if a grant issues that cycle, otherwise to IDLE.
- Flush: if_flush_i=1 in any cycle while BUSY_IF is active sets drop_q.
  - While drop_q is set, the pending fetch response is suppressed (if_rvalid_o=0).
  - drop_q clears at the response cycle.
  - A flush in the response cycle itself also suppresses that response.
  - if_flush_i never cancels a grant issued in the same cycle.
- if_stall_o = if_req_i & ~if_gnt_o.
- Outputs not in use are 0: mem_*, rdata and rvalid all read 0 when not active.

## Timing
- Reset values: state=IDLE, starve_cnt=0, lat_cnt=0, drop_q=0. All outputs are 0 in the cycle after rst.
- Reset mid-access: the outstanding access is abandoned, and no rvalid is issued after reset.
- Latency: rvalid occurs exactly MEM_LATENCY cycles after the grant cycle.
- Throughput: one access per MEM_LATENCY cycles when back-to-back.
- Simultaneous requests in IDLE: only one grant is issued; the loser holds its request and sees gnt=0.
- Counter widths and saturation:
  - lat_cnt is 3 bits.
  - starve_cnt is 4 bits and saturates at STARVE_LIMIT.
- A requester must not change its address or data while req=1 and gnt=0. Behaviour on violation is undefined.

## Configuration
- IMEM_ARB_STARVE_GUARD_EN:
  - Defined: the starvation counter and the forced fetch win are as described above.
  - Undefined: starve_cnt is not built, and data wins every contested grant unconditionally.

## Test plan
- Fetch only, MEM_LATENCY=1, fetches to 0x1000 and 0x1004 back-to-back:
  - Grants occur in consecutive cycles.
  - Each if_rvalid_o comes one cycle later with the corresponding mem_rdata_i.
  - if_stall_o stays 0.
- Simultaneous requests, load to 0x2000 and fetch to 0x1000:
  - d_gnt_o=1 and if_stall_o=1 in the first cycle.
  - The fetch is granted in the next cycle, i.e. the load response cycle.
  - d_rvalid_o returns the load data.
- Guard enabled, STARVE_LIMIT=4, d_req_i held high continuously alongside a fetch request:
  - The fetch is granted on the 5th grant opportunity.
  - With the macro undefined, the fetch is never granted while d_req_i=1.
- MEM_LATENCY=3, fetch granted then if_flush_i pulsed at +1:
  - No if_rvalid_o is issued.
  - The next grant occurs at +3.
- Store, d_be_i=0b0011, addr 0x3000, wdata 0xDEADBEEF:
  - mem_we_o=1 and mem_be_o=0b0011 in the grant cycle.
  - d_rvalid_o=1 with d_rdata_o=0 after MEM_LATENCY cycles.
- rst asserted while BUSY_D with MEM_LATENCY=3:
  - All outputs read 0 in the cycle after rst.
  - No d_rvalid_o follows.
  - A fetch request in the first cycle after rst deasserts is granted that cycle.
